// File: rtl/pwm_bank_if.sv
// Control bus and PWM outputs of pwm_bank: shadow-duty writes, commit request and status.
interface pwm_bank_if #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CTR_LEN  = 8
);
    localparam int unsigned ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [CTR_LEN-1:0]  wr_data;
    logic                mode_in;
    logic                apply;
    logic                busy;
    logic                period_start;
    logic [CHANNELS-1:0] pwm;

    modport master (
        output wr_en, wr_addr, wr_data, mode_in, apply,
        input  busy, period_start, pwm
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, mode_in, apply,
        output busy, period_start, pwm
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: one shared phase counter, per-channel comparators,
// double-buffered duties committed together on a period boundary (edge or centre aligned).
module pwm_bank #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CTR_LEN  = 8,
    parameter bit          INVERT   = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    pwm_bank_if.slave bus
);
    localparam int unsigned         ADDR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned         PH_W    = CTR_LEN + 1;
    localparam logic [CTR_LEN-1:0]  CTR_MAX = '1;
    localparam logic [PH_W-1:0]     PH_MAX  = '1;
    localparam logic [CHANNELS-1:0] PWM_RST = {CHANNELS{INVERT}};

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PH_W-1:0]     phase_q;
    logic [PH_W-1:0]     phase_d;
    logic                mode_q;
    logic                mode_shadow_q;
    logic                busy_q;
    logic                period_start_q;
    logic [CHANNELS-1:0] pwm_q;
    logic [CHANNELS-1:0] raw;
    logic [CTR_LEN-1:0]  shadow_q [CHANNELS];
    logic [CTR_LEN-1:0]  active_q [CHANNELS];
    logic [CTR_LEN-1:0]  ctr;
    logic                boundary;
    logic                commit;
    logic                sample_mode;

    // Centre mode folds the upper half of the phase into a down-count: 0..MAX, MAX..0
    always_comb begin
        ctr = phase_q[CTR_LEN-1:0];
        if (mode_q && phase_q[CTR_LEN]) begin
            ctr = ~phase_q[CTR_LEN-1:0];
        end
    end

    assign boundary = mode_q ? (phase_q == PH_MAX)
                             : (phase_q[CTR_LEN-1:0] == CTR_MAX);

    // Commit request tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        sample_mode = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.apply) begin
                    sample_mode = 1'b1;
                    state_d     = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // apply is ignored here so the first request's mode is kept
                if (boundary) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A commit restarts the phase so a mode change begins with a clean period
    assign phase_d = commit ? '0 : phase_q + PH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= '0;
            mode_q         <= 1'b0;
            mode_shadow_q  <= 1'b0;
            busy_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            period_start_q <= (phase_d == '0);
            busy_q         <= (state_d == ST_PENDING);
            if (sample_mode) begin
                mode_shadow_q <= bus.mode_in;
            end
            if (commit) begin
                mode_q <= mode_shadow_q;
            end
        end
    end

    // Shadow and active duty banks; addresses beyond the last channel match nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (commit) begin
                    active_q[i] <= shadow_q[i];
                end
                if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
                    shadow_q[i] <= bus.wr_data;
                end
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            raw[i] = (ctr < active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= PWM_RST;
        end else begin
            pwm_q <= raw ^ PWM_RST;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.period_start = period_start_q;
    assign bus.pwm          = pwm_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: an arithmetic period model predicts every cycle's outputs
// for a normal and an inverted instance; directed windows measure duty counts and shapes.
module tb_pwm_bank;
    localparam int unsigned CH  = 6;
    localparam int unsigned N   = 3;
    localparam int unsigned AW  = $clog2(CH);
    localparam int          PER = 1 << N;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          busy;
        logic          ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    pwm_bank_if #(.CHANNELS(CH), .CTR_LEN(N)) bus ();
    pwm_bank_if #(.CHANNELS(CH), .CTR_LEN(N)) bus_inv ();

    assign bus_inv.wr_en   = bus.wr_en;
    assign bus_inv.wr_addr = bus.wr_addr;
    assign bus_inv.wr_data = bus.wr_data;
    assign bus_inv.mode_in = bus.mode_in;
    assign bus_inv.apply   = bus.apply;

    pwm_bank #(.CHANNELS(CH), .CTR_LEN(N), .INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    pwm_bank #(.CHANNELS(CH), .CTR_LEN(N), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .bus(bus_inv)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase position within a 2^(N+1) frame, duty arrays, pending flag
    int m_p = 0;
    int m_active [CH];
    int m_shadow [CH];
    bit m_mode = 1'b0;
    bit m_mode_sh = 1'b0;
    bit m_pending = 1'b0;
    exp_t exp_q [$];

    function automatic int ctr_of(input int p, input bit centre);
        if (!centre) return p % PER;
        return (p < PER) ? p : (2 * PER - 1 - p);
    endfunction

    function automatic bit is_boundary(input int p, input bit centre);
        if (centre) return p == 2 * PER - 1;
        return (p % PER) == PER - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   commit;
        if (!rst_n) begin
            m_p = 0; m_mode = 1'b0; m_mode_sh = 1'b0; m_pending = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_active[i] = 0;
                m_shadow[i] = 0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < CH; i++) e.pwm[i] = (ctr_of(m_p, m_mode) < m_active[i]);
            commit = m_pending && is_boundary(m_p, m_mode);
            if (commit) begin
                for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
                m_mode    = m_mode_sh;
                m_pending = 1'b0;
                m_p       = 0;
            end else begin
                m_p = (m_p + 1) % (2 * PER);
                if (bus.apply && !m_pending) begin
                    m_pending = 1'b1;
                    m_mode_sh = bus.mode_in;
                end
            end
            if (bus.wr_en && int'(bus.wr_addr) < CH) m_shadow[int'(bus.wr_addr)] = int'(bus.wr_data);
            e.busy = m_pending;
            e.ps   = (m_p == 0);
            exp_q.push_back(e);
        end
    end

    // Monitor: compares both instances against the model shortly after every edge
    always @(posedge clk) begin
        exp_t          e;
        logic [CH-1:0] inv_e;
        #1;
        if (!rst_n) begin
            check("rst_pwm", 32'(bus.pwm), 32'(0));
            check("rst_pwm_inv", 32'(bus_inv.pwm), 32'({CH{1'b1}}));
            check("rst_busy", 32'(bus.busy), 32'(0));
            check("rst_ps", 32'(bus.period_start), 32'(0));
        end else if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            inv_e = ~e.pwm;
            check("pwm", 32'(bus.pwm), 32'(e.pwm));
            check("pwm_inv", 32'(bus_inv.pwm), 32'(inv_e));
            check("busy", 32'(bus.busy), 32'(e.busy));
            check("period_start", 32'(bus.period_start), 32'(e.ps));
            check("busy_inv", 32'(bus_inv.busy), 32'(e.busy));
        end
    end

    int          win_hi  [CH];
    int          win_inv [CH];
    logic [31:0] win_pat [CH];

    task automatic sample_window(input int len);
        for (int i = 0; i < CH; i++) begin
            win_hi[i] = 0; win_inv[i] = 0; win_pat[i] = '0;
        end
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (bus.pwm[i]) begin
                    win_hi[i]++;
                    win_pat[i][k] = 1'b1;
                end
                if (!bus_inv.pwm[i]) win_inv[i]++;
            end
        end
    endtask

    task automatic write_shadow(input int a, input int d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = N'(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_apply(input bit m);
        @(negedge clk);
        bus.apply = 1'b1; bus.mode_in = m;
        @(negedge clk);
        bus.apply = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 64);
        check(name, 32'(bus.period_start), 32'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int n;
        int exp_final [CH];
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.mode_in = 1'b0; bus.apply = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ps_after_release", 32'(bus.period_start), 32'(0));

        // T1: single channel duty 3 in edge mode
        write_shadow(2, 3);
        do_apply(1'b0);
        check("t1_busy", 32'(bus.busy), 32'(1));
        wait_ps("t1_ps");
        sample_window(PER);
        check("t1_hi2", 32'(win_hi[2]), 32'(3));
        check("t1_pat2", win_pat[2], 32'h07);
        check("t1_hi0", 32'(win_hi[0]), 32'(0));
        check("t1_inv2", 32'(win_inv[2]), 32'(3));

        // T2: maximum duty
        write_shadow(1, 7);
        do_apply(1'b0);
        wait_ps("t2_ps");
        sample_window(PER);
        check("t2_hi1", 32'(win_hi[1]), 32'(7));
        check("t2_inv1", 32'(win_inv[1]), 32'(7));

        // T3: centre mode, six contiguous high cycles across the phase wrap
        write_shadow(3, 3);
        do_apply(1'b1);
        wait_ps("t3_ps");
        sample_window(2 * PER);
        check("t3_hi3", 32'(win_hi[3]), 32'(6));
        check("t3_pat3", win_pat[3], 32'hE007);
        check("t3_hi1", 32'(win_hi[1]), 32'(14));

        // T4: shadow write alone has no effect; second apply while busy is ignored
        write_shadow(0, 5);
        repeat (3 * 2 * PER) @(negedge clk);
        sample_window(2 * PER);
        check("t4_no_apply", 32'(win_hi[0]), 32'(0));
        @(negedge clk);
        bus.apply = 1'b1; bus.mode_in = 1'b0;
        @(negedge clk);
        bus.apply = 1'b1; bus.mode_in = 1'b1;
        @(negedge clk);
        bus.apply = 1'b0;
        wait_ps("t4_ps");
        sample_window(2 * PER);
        check("t4_pat0_edge", win_pat[0], 32'h1F1F);

        // T5: apply in a boundary cycle commits one period later
        write_shadow(4, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!is_boundary(m_p, m_mode) && n < 64);
        bus.apply = 1'b1; bus.mode_in = 1'b0;
        @(negedge clk);
        bus.apply = 1'b0;
        bcnt = 0;
        while (bus.busy && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
        check("t5_commit_delay", 32'(bcnt), 32'(PER));

        // T5: write on the commit edge lands in shadow only
        write_shadow(5, 2);
        do_apply(1'b0);
        n = 0;
        while (!(m_pending && is_boundary(m_p, m_mode)) && n < 64) begin
            @(negedge clk);
            n++;
        end
        bus.wr_en = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = N'(7);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("t5_commit_ps", 32'(bus.period_start), 32'(1));
        sample_window(PER);
        check("t5_old_value", 32'(win_hi[5]), 32'(2));

        // T5: out-of-range addresses are dropped
        write_shadow(6, 5);
        write_shadow(7, 1);
        do_apply(1'b0);
        wait_ps("t5_ps");
        sample_window(PER);
        exp_final = '{5, 7, 3, 3, 2, 7};
        for (int i = 0; i < CH; i++) begin
            check($sformatf("t5_final_hi%0d", i), 32'(win_hi[i]), 32'(exp_final[i]));
            check($sformatf("t5_final_inv%0d", i), 32'(win_inv[i]), 32'(exp_final[i]));
        end

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = AW'($urandom_range(0, 7));
            bus.wr_data = N'($urandom_range(0, 7));
            bus.apply   = ($urandom_range(0, 15) == 0);
            bus.mode_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.wr_en = 1'b0; bus.apply = 1'b0;
        wait_idle("pre_t6_idle");

        // T6: asynchronous reset while a commit is pending
        do_apply(1'b1);
        check("t6_busy", 32'(bus.busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_pwm", 32'(bus.pwm), 32'(0));
        check("t6_pwm_inv", 32'(bus_inv.pwm), 32'({CH{1'b1}}));
        check("t6_busy_rst", 32'(bus.busy), 32'(0));
        check("t6_ps_rst", 32'(bus.period_start), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("t6_ps_release", 32'(bus.period_start), 32'(0));
        do_apply(1'b0);
        wait_ps("t6_ps");
        sample_window(2 * PER);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("t6_zero%0d", i), 32'(win_hi[i]), 32'(0));
        end

        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_addr = AW'($urandom_range(0, 7));
            bus.wr_data = N'($urandom_range(0, 7));
            bus.apply   = ($urandom_range(0, 7) == 0);
            bus.mode_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.wr_en = 1'b0; bus.apply = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
